// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants and the write-back request type
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int NREG = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: one-hot write-back grant; round-robin when WB_RR_ARB_EN is defined, else fixed priority
module wb_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NREQ-1:0] valid,
  input  logic            xfer,
  output logic [NREQ-1:0] grant
);
`ifdef WB_RR_ARB_EN
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [NREQ-1:0] masked;
  // requesters at or above the pointer get first pick, otherwise wrap to the lowest
  assign masked = valid & ({NREQ{1'b1}} << ptr);
  assign grant = |masked ? masked & (~masked + NREQ'(1)) : valid & (~valid + NREQ'(1));
  always_comb begin
    ptr_nxt = ptr;
    for (int i = 0; i < NREQ; i++)
      if (xfer && grant[i]) ptr_nxt = PW'((i + 1) % NREQ);
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) ptr <= '0;
    else ptr <= ptr_nxt;
`else
  logic unused_rr;
  assign grant = valid & (~valid + NREQ'(1));
  assign unused_rr = ^{CLK, RST_N, xfer};
`endif
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: shares the register-file write port between requesters and tracks pending writes (WB_RR_ARB_EN selects round-robin)
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = regfile_pkg::XLEN
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NREQ-1:0]        REQ_VALID,
  input  logic [REG_AW*NREQ-1:0] REQ_ADDR,
  input  logic [XLEN*NREQ-1:0]   REQ_DATA,
  output logic [NREQ-1:0]        REQ_READY,
  output logic [REG_AW-1:0]      RF_A3,
  output logic [XLEN-1:0]        RF_WD3,
  output logic                   RF_WE,
  input  logic                   ISSUE_VALID,
  input  logic [REG_AW-1:0]      ISSUE_RD,
  output logic                   ISSUE_READY,
  input  logic [REG_AW-1:0]      Q1_ADDR,
  input  logic [REG_AW-1:0]      Q2_ADDR,
  output logic                   BUSY1,
  output logic                   BUSY2
);
  logic [NREQ-1:0]   grant;
  logic              xfer;
  logic [REG_AW-1:0] sel_addr;
  logic [XLEN-1:0]   sel_data;
  logic [NREG-1:0]   busy, clr, set;
  wb_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .CLK   (CLK),
    .RST_N (RST_N),
    .valid (REQ_VALID),
    .xfer  (xfer),
    .grant (grant)
  );
  assign REQ_READY = RST_N ? grant : '0;
  assign xfer = |(REQ_VALID & REQ_READY);
  always_comb begin
    sel_addr = REG_ZERO;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) begin
        sel_addr = REQ_ADDR[REG_AW*i +: REG_AW];
        sel_data = REQ_DATA[XLEN*i +: XLEN];
      end
  end
  // x0 writes are accepted but never reach the register file
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      RF_WE  <= 1'b0;
      RF_A3  <= REG_ZERO;
      RF_WD3 <= '0;
    end else begin
      RF_WE <= xfer && sel_addr != REG_ZERO;
      if (xfer) begin
        RF_A3  <= sel_addr;
        RF_WD3 <= sel_data;
      end
    end
  assign clr = RF_WE ? NREG'(1) << RF_A3 : '0;
  assign set = ISSUE_VALID && ISSUE_READY && ISSUE_RD != REG_ZERO ? NREG'(1) << ISSUE_RD : '0;
  assign ISSUE_READY = !busy[ISSUE_RD] || clr[ISSUE_RD];
  // set after clear so a newly issued producer wins over the retiring one
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) busy <= '0;
    else busy <= ((busy & ~clr) | set) & ~NREG'(1);
  assign BUSY1 = busy[Q1_ADDR];
  assign BUSY2 = busy[Q2_ADDR];
  spurious_wb: assert property (@(posedge CLK) disable iff (!RST_N) RF_WE |-> busy[RF_A3])
    else $warning("write-back to non-busy register x%0d", RF_A3);
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-back controller and scoreboard for the 32x32 RV32 register file.
- Shares the register file's single write port (address, data, write-enable) between NREQ write-back requesters using a valid/ready handshake.
- Tracks pending writes per register so decode can stall on read-after-write hazards.
- Sits between the execute/load units and the register file; decode talks to it through the issue and query ports.

Parameters:
- NREQ, 2, number of write-back requesters (index 0 = ALU, 1 = load unit); legal range 1..4.
- XLEN, 32, data width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  NREQ  per-requester write-back valid.
- REQ_ADDR  in  5*NREQ  destination register, requester i in bits [5i+4:5i].
- REQ_DATA  in  XLEN*NREQ  write data, requester i in bits [XLEN*i+XLEN-1:XLEN*i].
- REQ_READY  out  NREQ  grant/accept, one-hot or zero, combinational.
- RF_A3  out  5  register-file write address, registered.
- RF_WD3  out  XLEN  register-file write data, registered.
- RF_WE  out  1  register-file write enable, registered.
- ISSUE_VALID  in  1  decode issues an instruction that writes ISSUE_RD.
- ISSUE_RD  in  5  destination of the issued instruction.
- ISSUE_READY  out  1  issue accepted; low when busy[ISSUE_RD] is 1 and not being cleared this cycle.
- Q1_ADDR, Q2_ADDR  in  5 each  source registers to check.
- BUSY1, BUSY2  out  1 each  busy[Qn_ADDR], combinational; always 0 for x0.

Behaviour:
- Reset (RST_N low, asynchronous):
  - RF_WE=0, RF_A3=0, RF_WD3=0.
  - busy[31:0]=0, arbitration pointer=0.
  - In-flight grants are discarded; REQ_READY=0 while in reset.
- Arbitration (combinational):
  - Among asserted REQ_VALID, exactly one REQ_READY is raised per cycle.
  - A transfer occurs when REQ_VALID[i] and REQ_READY[i] are both 1 at a rising edge.
  - REQ_READY never depends on REQ_READY of the same requester; no combinational loop.
- Write-port latency:
  - A transfer at edge N drives RF_A3/RF_WD3 from that edge and RF_WE=1 for exactly one cycle.
  - The register file commits at edge N+1.
  - Maximum throughput is one write per cycle.
- x0 handling:
  - A transfer with address 0 is accepted (REQ_READY high) but produces RF_WE=0.
  - busy[0] is hard-wired to 0.
- Scoreboard set: on an issue handshake (ISSUE_VALID and ISSUE_READY) with ISSUE_RD≠0, busy[ISSUE_RD] is set to 1.
- Scoreboard clear: at each edge where RF_WE=1, busy[RF_A3] is cleared, i.e. at the same edge the register file commits. A query after that edge sees busy=0 and the new data together.
- Simultaneous set and clear of the same register: the set wins, because a new producer has been issued. ISSUE_READY is high in that case.
- Issue to a busy register not being cleared: ISSUE_READY=0; decode holds ISSUE_VALID and ISSUE_RD stable.
- Write-back to a non-busy register (spurious): the write is still performed and busy stays 0. Simulation-only assertion flags it.
- Requesters must hold REQ_ADDR/REQ_DATA stable while valid and not ready.

Optional Feature:
- Macro: WB_RR_ARB_EN.
- Defined:
  - Round-robin arbitration; the pointer advances to (granted index + 1) mod NREQ after each transfer.
  - The pointer is unchanged on cycles with no transfer.
  - Guarantees a requester waits at most NREQ-1 transfers.
- Undefined:
  - Fixed priority; the lowest index wins.
  - No pointer register exists.

Decomposition:
- Package regfile_pkg:
  - XLEN=32, REG_AW=5, NREG=32.
  - REG_ZERO=5'd0.
  - Packed type for one write-back request {addr, data}.
- One sub-module: wb_rr_arbiter.
  - Inputs: valid vector, transfer strobe.
  - Output: one-hot grant.
  - Contains the optional round-robin pointer; fixed priority when WB_RR_ARB_EN is undefined.
- Scoreboard and write-port registers stay in regfile_wb_ctrl.

Test Plan:
- Reset mid-write: RF_WE=1 then RST_N low -> RF_WE, RF_A3, RF_WD3 and all busy bits 0 immediately, without waiting for a clock edge.
- Issue ISSUE_RD=5 -> BUSY1=1 for Q1_ADDR=5. Then ALU valid, addr=5, data=0xDEADBEEF -> REQ_READY[0]=1, next cycle RF_WE=1/RF_A3=5/RF_WD3=0xDEADBEEF, and BUSY1=0 after the following edge.
- Both requesters valid for 4 cycles, addrs 3 and 4:
  - WB_RR_ARB_EN defined -> grants alternate 0,1,0,1.
  - WB_RR_ARB_EN undefined -> requester 0 granted every cycle.
- Write-back to x0 with data 0x1234 -> REQ_READY=1, RF_WE stays 0, BUSY1 for Q1_ADDR=0 is 0 throughout.
- busy[7]=1 and a second issue to 7 with no write-back -> ISSUE_READY=0. Same issue in the cycle RF_WE=1, RF_A3=7 -> ISSUE_READY=1 and busy[7] remains 1.
- Load valid with ALU idle for 3 back-to-back writes to 1, 2, 3 -> RF_WE high for 3 consecutive cycles, addresses in order.
